rom_arbiter: RTL and testbench
==============================

# rom_arbiter

Shares the single read port of the program ROM (12-bit word address, 32-bit combinational data) between the instruction-fetch unit and the load unit. Each requester uses a valid/ready request channel and a valid/ready response channel. The block applies round-robin arbitration, alignment and range checking, and byte-to-word address conversion. It sits between the core's fetch/load stages and the ROM instance, with one access in flight at a time.

## Interface
- `ADDR_W`, 12: ROM word-address width; the ROM holds 2^ADDR_W words.
- `DATA_W`, 32: ROM word width.
- `BASE_ADDR`, 32'h0000_0000: byte address mapped to ROM word 0.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `if_req_valid` / `ld_req_valid`  in  1  request present.
- `if_req_ready` / `ld_req_ready`  out  1  request accepted this cycle.
- `if_req_addr` / `ld_req_addr`  in  32  byte address.
- `if_resp_valid` / `ld_resp_valid`  out  1  response present.
- `if_resp_ready` / `ld_resp_ready`  in  1  requester takes the response.
- `if_resp_data` / `ld_resp_data`  out  DATA_W  read word.
- `if_resp_err` / `ld_resp_err`  out  1  misaligned or out-of-range access.
- `rom_address`  out  ADDR_W  word address to the ROM.
- `rom_data_out`  in  DATA_W  ROM read data (combinational from `rom_address`).
- `busy`  out  1  state is not IDLE.

## Operation
- FSM states: IDLE, READ, RESP.
  - IDLE → READ on any accepted request.
  - READ → RESP unconditionally.
  - RESP → IDLE when the owning port's `resp_ready` is 1.
- Arbitration happens in IDLE only.
  - If only one port has `valid=1`, that port is granted.
  - If both are valid, the port that was not granted last wins.
  - The `last_grant` register is updated on every acceptance. Its reset value is LD, so IF wins the first conflict.
- `X_req_ready = (state==IDLE) && X_req_valid && grant==X`. Ready depends on valid; a requester must not wait for ready before asserting valid.
- On accept, the block registers `owner_q`, `addr_q` and `err_q`.
  - `err_q` = `addr[1:0]!=0` or `(addr-BASE_ADDR) >= 4*2^ADDR_W`. The subtraction is 32-bit unsigned, so an address below BASE wraps and is flagged.
  - `word_addr` = `(addr-BASE_ADDR)[ADDR_W+1:2]`.
- `rom_address` is driven from `addr_q` at all times; it is stable outside READ.
- At the end of READ, `resp_data_q` captures `rom_data_out`, or 0 if `err_q`. An errored access still takes the same latency.
- In RESP, only the owner's `resp_valid` is 1. `resp_data`/`resp_err` are driven to both ports but are meaningful only when valid. The non-owner's `resp_valid` is 0.
- `resp_valid` stays high and data stays stable until `resp_ready` is 1. This is a standard valid/ready hold.
- Reset mid-access: the FSM is forced to IDLE asynchronously, and any pending response is discarded without being delivered.
- Reset values: state IDLE, `last_grant` LD, `addr_q` 0, `rom_address` 0, `resp_data` 0, `resp_err` 0, both `resp_valid` 0, `busy` 0. Both `req_ready` are 0 while `rst_n=0`.

## Timing
- Accept at edge N (IDLE). READ during cycle N+1. `resp_valid` is high from cycle N+2.
- With `resp_ready` tied high, the cycle sequence is IDLE, READ, RESP, IDLE. The next acceptance can happen in cycle N+3, so peak throughput is one access per 3 cycles.
- Requests presented while busy see ready=0 and must hold `valid` and `addr` stable.
- A request valid in the same cycle the RESP→IDLE transition occurs is seen in the following IDLE cycle; there is no bypass.

## Structure
- Package `rom_arb_pkg` holds:
  - `typedef enum logic [1:0] {IDLE, READ, RESP} arb_state_t`
  - `typedef enum logic {PORT_IF, PORT_LD} port_id_t`
  - localparam `ROM_BYTES = 4*2**ADDR_W` (default 16384)
- Sub-module `rom_addr_check` is combinational. It takes a byte address and outputs the word address and the error flag.
- The top-level module holds the FSM, arbitration and response registers.

## Test plan
- **IF read:** IF requests 32'h4 with `resp_ready=1`.
  - Ready at cycle 0, `rom_address=1` in cycle 1, `if_resp_valid` in cycle 2.
  - `if_resp_data` equals ROM word 1, `err=0`.
- **Simultaneous requests:** IF (0x0) and LD (0x8) are both valid from reset and held.
  - IF is granted first and LD is granted in the next IDLE.
  - `ld_resp_data` equals word 2.
  - Over 4 further conflicts, the grants alternate.
- **Error cases:** LD requests 32'h2 (misaligned), then 32'h4000 (out of range, default params).
  - Both return `ld_resp_err=1` and data 0 at the normal 2-cycle latency.
- **Backpressure:** IF request with `if_resp_ready=0` for 5 cycles.
  - `resp_valid`/`data` are held stable and `busy=1`.
  - LD requests during that time see `ld_req_ready=0`.
  - Both complete after `resp_ready` rises.
- **Reset mid-access:** assert `rst_n=0` during READ.
  - All outputs return to their reset values immediately and no response is delivered.
  - The first post-reset conflict grants IF.

Source files
------------

// File: rtl/rom_arb_pkg.sv
// Shared types and constants for the program-ROM read-port arbiter.
package rom_arb_pkg;

    typedef enum logic [1:0] {IDLE, READ, RESP} arb_state_t;

    typedef enum logic {PORT_IF, PORT_LD} port_id_t;

    localparam int unsigned ADDR_W_DEFAULT = 12;
    localparam int unsigned ROM_BYTES      = 4 * 2 ** ADDR_W_DEFAULT;

endpackage

// File: rtl/rom_addr_check.sv
// Byte-to-word address conversion with alignment and ROM range checking.
module rom_addr_check #(
    parameter int unsigned ADDR_W    = 12,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic [31:0]       byte_addr,
    output logic [ADDR_W-1:0] word_addr_c,
    output logic              err_c
);

    // One past the last ROM byte; 33 bits so a full 32-bit window cannot overflow
    localparam logic [32:0] LIMIT = 33'(1) << (ADDR_W + 2);

    logic [31:0] offset_c;

    // Unsigned wrap makes addresses below the base land far out of range
    assign offset_c    = byte_addr - BASE_ADDR;
    assign word_addr_c = offset_c[ADDR_W+1:2];
    assign err_c       = (byte_addr[1:0] != 2'b00) || ({1'b0, offset_c} >= LIMIT);

endmodule

// File: rtl/rom_arbiter.sv
// Round-robin sharing of the single program-ROM read port between fetch and load.
module rom_arbiter
    import rom_arb_pkg::*;
#(
    parameter int unsigned ADDR_W    = 12,
    parameter int unsigned DATA_W    = 32,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req_valid,
    output logic              if_req_ready,
    input  logic [31:0]       if_req_addr,
    output logic              if_resp_valid,
    input  logic              if_resp_ready,
    output logic [DATA_W-1:0] if_resp_data,
    output logic              if_resp_err,
    input  logic              ld_req_valid,
    output logic              ld_req_ready,
    input  logic [31:0]       ld_req_addr,
    output logic              ld_resp_valid,
    input  logic              ld_resp_ready,
    output logic [DATA_W-1:0] ld_resp_data,
    output logic              ld_resp_err,
    output logic [ADDR_W-1:0] rom_address,
    input  logic [DATA_W-1:0] rom_data_out,
    output logic              busy
);

    arb_state_t        state_q, state_d;
    port_id_t          last_grant_q, last_grant_d;
    port_id_t          owner_q, owner_d;
    port_id_t          grant_c;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] resp_data_q, resp_data_d;
    logic              resp_err_q, resp_err_d;
    logic [31:0]       sel_addr_c;
    logic [ADDR_W-1:0] word_addr_c;
    logic              addr_err_c;
    logic              accept_c;
    logic              owner_ready_c;

    // On a conflict the port not granted last time wins
    always_comb begin
        grant_c = PORT_IF;
        if (if_req_valid && ld_req_valid) begin
            grant_c = (last_grant_q == PORT_LD) ? PORT_IF : PORT_LD;
        end else if (ld_req_valid) begin
            grant_c = PORT_LD;
        end
    end

    assign sel_addr_c = (grant_c == PORT_LD) ? ld_req_addr : if_req_addr;

    rom_addr_check #(
        .ADDR_W    (ADDR_W),
        .BASE_ADDR (BASE_ADDR)
    ) u_addr_check (
        .byte_addr   (sel_addr_c),
        .word_addr_c (word_addr_c),
        .err_c       (addr_err_c)
    );

    // rst_n gating keeps ready low for the whole reset window
    assign if_req_ready  = rst_n && (state_q == IDLE) && if_req_valid && (grant_c == PORT_IF);
    assign ld_req_ready  = rst_n && (state_q == IDLE) && ld_req_valid && (grant_c == PORT_LD);
    assign accept_c      = if_req_ready || ld_req_ready;
    assign owner_ready_c = (owner_q == PORT_IF) ? if_resp_ready : ld_resp_ready;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        addr_d       = addr_q;
        err_d        = err_q;
        resp_data_d  = resp_data_q;
        resp_err_d   = resp_err_q;
        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    state_d      = READ;
                    last_grant_d = grant_c;
                    owner_d      = grant_c;
                    addr_d       = word_addr_c;
                    err_d        = addr_err_c;
                end
            end
            READ: begin
                // Errored accesses still spend the READ cycle but return zero data
                state_d     = RESP;
                resp_data_d = err_q ? '0 : rom_data_out;
                resp_err_d  = err_q;
            end
            RESP: begin
                if (owner_ready_c) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= PORT_LD;
            owner_q      <= PORT_IF;
            addr_q       <= '0;
            err_q        <= 1'b0;
            resp_data_q  <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            addr_q       <= addr_d;
            err_q        <= err_d;
            resp_data_q  <= resp_data_d;
            resp_err_q   <= resp_err_d;
        end
    end

    assign rom_address   = addr_q;
    assign busy          = (state_q != IDLE);
    assign if_resp_valid = (state_q == RESP) && (owner_q == PORT_IF);
    assign ld_resp_valid = (state_q == RESP) && (owner_q == PORT_LD);
    assign if_resp_data  = resp_data_q;
    assign ld_resp_data  = resp_data_q;
    assign if_resp_err   = resp_err_q;
    assign ld_resp_err   = resp_err_q;

endmodule

// File: tb/tb_rom_arbiter.sv
// Self-checking bench for rom_arbiter: directed scenarios plus randomized rounds.
module tb_rom_arbiter;
    import rom_arb_pkg::*;

    localparam logic [31:0] BASE = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_req_valid = 1'b0, ld_req_valid = 1'b0;
    logic        if_req_ready, ld_req_ready;
    logic [31:0] if_req_addr = 32'h0, ld_req_addr = 32'h0;
    logic        if_resp_valid, ld_resp_valid;
    logic        if_resp_ready = 1'b0, ld_resp_ready = 1'b0;
    logic [31:0] if_resp_data, ld_resp_data;
    logic        if_resp_err, ld_resp_err;
    logic [11:0] rom_address;
    logic [31:0] rom_data_out;
    logic        busy;

    logic [31:0] mem [4096];

    int vectors = 0;
    int miscompares = 0;

    // Reference-model state: pending requests per port and who won last
    bit          if_pend = 0, ld_pend = 0;
    logic [31:0] if_a = 32'h0, ld_a = 32'h0;
    bit          last_ld = 1;

    always #5 clk = ~clk;

    assign rom_data_out = mem[rom_address];

    rom_arbiter dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .if_req_valid  (if_req_valid),
        .if_req_ready  (if_req_ready),
        .if_req_addr   (if_req_addr),
        .if_resp_valid (if_resp_valid),
        .if_resp_ready (if_resp_ready),
        .if_resp_data  (if_resp_data),
        .if_resp_err   (if_resp_err),
        .ld_req_valid  (ld_req_valid),
        .ld_req_ready  (ld_req_ready),
        .ld_req_addr   (ld_req_addr),
        .ld_resp_valid (ld_resp_valid),
        .ld_resp_ready (ld_resp_ready),
        .ld_resp_data  (ld_resp_data),
        .ld_resp_err   (ld_resp_err),
        .rom_address   (rom_address),
        .rom_data_out  (rom_data_out),
        .busy          (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit exp_err(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return (a[1:0] != 2'b00) || (off >= 32'(ROM_BYTES));
    endfunction

    function automatic logic [11:0] exp_word(input logic [31:0] a);
        logic [31:0] off;
        off = (a - BASE) >> 2;
        return off[11:0];
    endfunction

    function automatic logic [31:0] exp_data(input logic [31:0] a);
        return exp_err(a) ? 32'h0 : mem[exp_word(a)];
    endfunction

    function automatic logic [31:0] rand_addr();
        int unsigned r;
        r = $urandom_range(0, 9);
        if (r < 7) return {18'h0, 12'($urandom_range(0, 4095)), 2'b00};
        if (r == 7) return {18'h0, 12'($urandom_range(0, 4095)), 2'($urandom_range(1, 3))};
        if (r == 8) return 32'h0000_4000 + {18'h0, 12'($urandom_range(0, 4095)), 2'b00};
        return 32'hFFFF_FFFC;
    endfunction

    task automatic post_if(input logic [31:0] a);
        if_pend = 1; if_a = a;
    endtask

    task automatic post_ld(input logic [31:0] a);
        ld_pend = 1; ld_a = a;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},     32'(busy),          32'h0);
        check({tag, "_if_rv"},    32'(if_resp_valid), 32'h0);
        check({tag, "_ld_rv"},    32'(ld_resp_valid), 32'h0);
        check({tag, "_if_rdy"},   32'(if_req_ready),  32'h0);
        check({tag, "_ld_rdy"},   32'(ld_req_ready),  32'h0);
        check({tag, "_rom_addr"}, 32'(rom_address),   32'h0);
        check({tag, "_data"},     if_resp_data,       32'h0);
        check({tag, "_err"},      32'(if_resp_err),   32'h0);
    endtask

    // One access from an IDLE negedge through response handshake; optional LD request raised while busy
    task automatic round(input int hold, input bit late_ld, input logic [31:0] late_addr);
        bit          w_ld;
        logic [31:0] a, d;
        bit          e;
        if_req_valid = if_pend; if_req_addr = if_a;
        ld_req_valid = ld_pend; ld_req_addr = ld_a;
        w_ld = (if_pend && ld_pend) ? !last_ld : ld_pend;
        a = w_ld ? ld_a : if_a;
        d = exp_data(a);
        e = exp_err(a);
        #1;
        check("grant_if", 32'(if_req_ready), 32'(!w_ld));
        check("grant_ld", 32'(ld_req_ready), 32'(w_ld));
        @(posedge clk);
        #1;
        last_ld = w_ld;
        if (w_ld) begin ld_pend = 0; ld_req_valid = 0; end
        else begin if_pend = 0; if_req_valid = 0; end
        @(negedge clk);
        check("read_busy", 32'(busy), 32'h1);
        check("read_rom_addr", 32'(rom_address), 32'(exp_word(a)));
        check("read_no_valid", 32'({if_resp_valid, ld_resp_valid}), 32'h0);
        check("read_no_ready", 32'({if_req_ready, ld_req_ready}), 32'h0);
        if (late_ld) begin
            post_ld(late_addr);
            ld_req_valid = 1; ld_req_addr = late_addr;
        end
        @(negedge clk);
        check("resp_valid", 32'({if_resp_valid, ld_resp_valid}), w_ld ? 32'h1 : 32'h2);
        check("resp_data", w_ld ? ld_resp_data : if_resp_data, d);
        check("resp_err", 32'(w_ld ? ld_resp_err : if_resp_err), 32'(e));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid", 32'({if_resp_valid, ld_resp_valid}), w_ld ? 32'h1 : 32'h2);
            check("hold_data", w_ld ? ld_resp_data : if_resp_data, d);
            check("hold_busy", 32'(busy), 32'h1);
            check("hold_no_ready", 32'({if_req_ready, ld_req_ready}), 32'h0);
        end
        if (w_ld) ld_resp_ready = 1; else if_resp_ready = 1;
        @(negedge clk);
        if_resp_ready = 0; ld_resp_ready = 0;
        check("done_idle", 32'({busy, if_resp_valid, ld_resp_valid}), 32'h0);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = $urandom;

        // Reset state, with requests already asserted
        if_req_valid = 1; ld_req_valid = 1;
        #2;
        check_reset_outputs("reset");
        if_req_valid = 0; ld_req_valid = 0;
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);

        // Plain IF read of word 1
        post_if(32'h4);
        round(0, 0, 32'h0);

        // Simultaneous from reset: IF first, then LD, then alternating conflicts
        rst_n = 0; last_ld = 1;
        post_if(32'h0); post_ld(32'h8);
        if_req_valid = 1; ld_req_valid = 1;
        #1;
        check("rst_hold_rdy", 32'({if_req_ready, ld_req_ready}), 32'h0);
        @(negedge clk);
        rst_n = 1;
        round(0, 0, 32'h0);
        round(0, 0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            if (!if_pend) post_if(rand_addr());
            if (!ld_pend) post_ld(rand_addr());
            round(0, 0, 32'h0);
        end
        while (if_pend || ld_pend) round(0, 0, 32'h0);

        // Misaligned and out-of-range loads
        post_ld(32'h2);
        round(0, 0, 32'h0);
        post_ld(32'h4000);
        round(0, 0, 32'h0);
        post_ld(32'h3FFC);
        round(0, 0, 32'h0);

        // Backpressure with a load arriving while busy
        post_if(32'h100);
        round(5, 1, 32'h200);
        round(0, 0, 32'h0);

        // Reset during READ discards the access
        post_if(32'h40);
        if_req_valid = 1; if_req_addr = 32'h40;
        @(posedge clk);
        #1;
        if_pend = 0; if_req_valid = 0;
        @(negedge clk);
        rst_n = 0;
        #1;
        check_reset_outputs("midrst");
        last_ld = 1;
        repeat (2) @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        check("post_rst_no_resp", 32'({busy, if_resp_valid, ld_resp_valid}), 32'h0);
        post_if(32'h10); post_ld(32'h20);
        round(0, 0, 32'h0);
        round(0, 0, 32'h0);

        // Randomized rounds
        for (int n = 0; n < 40; n++) begin
            if (!if_pend && $urandom_range(0, 1) == 1) post_if(rand_addr());
            if (!ld_pend && $urandom_range(0, 1) == 1) post_ld(rand_addr());
            if (!if_pend && !ld_pend) post_ld(rand_addr());
            round(int'($urandom_range(0, 3)), 0, 32'h0);
        end
        while (if_pend || ld_pend) round(0, 0, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
